conv_sequencer: RTL and testbench

Parametrised convolution controller that sequences one output tile through the datapath: per kernel position it streams weights from input SRAM into L0, loads them into the MAC array, streams the shifted activation window, executes, and drains OFIFO results into psum SRAM with SFU accumulate control. It replaces the fixed 3x3 / 6x6 controller with counter-based address generation for any kernel size and input width. It adds three capabilities to the earlier controller:
- L0 back-pressure stalls.
- An explicit OFIFO drain phase.
- done/busy status.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv_addr_gen.sv | 98 +++++++++
 rtl/conv_sequencer.sv | 163 ++++++++++++++++
 tb/tb_conv_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state, instruction codes and geometry helpers for conv_sequencer
package conv_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WGT_LOAD,
        S_WGT_FEED,
        S_ACT_LOAD,
        S_ACT_FEED,
        S_DRAIN,
        S_DONE
    } conv_state_t;

    localparam logic [1:0] INST_IDLE  = 2'b00;
    localparam logic [1:0] INST_KLOAD = 2'b01;
    localparam logic [1:0] INST_EXEC  = 2'b10;

    localparam int CNT_W = 16;

    function automatic int conv_out_w(input int in_w, input int ksize);
        return in_w - ksize + 1;
    endfunction

    function automatic int conv_npix(input int in_w, input int ksize);
        return conv_out_w(in_w, ksize) * conv_out_w(in_w, ksize);
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - kernel-position and window counters driving the input SRAM address
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int ROW      = 8,
    parameter int KSIZE    = 3,
    parameter int IN_W     = 6,
    parameter int ADDR_W   = 7,
    parameter int ACT_BASE = 72
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              kpos_step,
    input  logic              act_step,
    input  logic              sel_act,
    input  logic [ADDR_W-1:0] wgt_cnt,
    output logic [ADDR_W-1:0] i_a
);

    localparam int OUT_W = conv_out_w(IN_W, KSIZE);
    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ROW_A  = ADDR_W'(ROW);
    localparam logic [ADDR_W-1:0] INW_A  = ADDR_W'(IN_W);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(ACT_BASE);
    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(KSIZE - 1);
    localparam logic [ADDR_W-1:0] O_LAST = ADDR_W'(OUT_W - 1);

    logic [ADDR_W-1:0] ki_q, ki_d, kj_q, kj_d, ox_q, ox_d, oy_q, oy_d;
    logic [ADDR_W-1:0] ki_off_q, ki_off_d, row_off_q, row_off_d, wbase_q, wbase_d;

    // Offsets are stepped by addition so the datapath never multiplies.
    always_comb begin
        ki_d      = ki_q;
        kj_d      = kj_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        ki_off_d  = ki_off_q;
        row_off_d = row_off_q;
        wbase_d   = wbase_q;
        if (clr) begin
            ki_d      = '0;
            kj_d      = '0;
            ox_d      = '0;
            oy_d      = '0;
            ki_off_d  = '0;
            row_off_d = '0;
            wbase_d   = '0;
        end else begin
            if (kpos_step) begin
                wbase_d = wbase_q + ROW_A;
                if (kj_q == K_LAST) begin
                    kj_d     = '0;
                    ki_d     = ki_q + A_ONE;
                    ki_off_d = ki_off_q + INW_A;
                end else begin
                    kj_d = kj_q + A_ONE;
                end
            end
            if (act_step) begin
                if (ox_q == O_LAST) begin
                    ox_d = '0;
                    if (oy_q == O_LAST) begin
                        oy_d      = '0;
                        row_off_d = '0;
                    end else begin
                        oy_d      = oy_q + A_ONE;
                        row_off_d = row_off_q + INW_A;
                    end
                end else begin
                    ox_d = ox_q + A_ONE;
                end
            end
        end
        i_a = sel_act ? (BASE_A + ki_off_q + row_off_q + kj_q + ox_q) : (wbase_q + wgt_cnt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ki_q      <= '0;
            kj_q      <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            ki_off_q  <= '0;
            row_off_q <= '0;
            wbase_q   <= '0;
        end else begin
            ki_q      <= ki_d;
            kj_q      <= kj_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            ki_off_q  <= ki_off_d;
            row_off_q <= row_off_d;
            wbase_q   <= wbase_d;
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - per-kernel-position weight/activation/drain sequencer for one output tile
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int ROW      = 8,
    parameter int COL      = 8,
    parameter int KSIZE    = 3,
    parameter int IN_W     = 6,
    parameter int ADDR_W   = 7,
    parameter int ACT_BASE = 72,
    parameter int FLUSH    = ROW + COL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] i_a,
    output logic              i_cen,
    output logic              i_wen,
    output logic              l0_wr,
    output logic              l0_rd,
    input  logic              l0_full,
    output logic [1:0]        inst_w,
    input  logic              of_valid,
    output logic              of_rd,
    output logic [ADDR_W-1:0] p_a,
    output logic              p_cen,
    output logic              p_wen,
    output logic              acc
);

    localparam int NKIJ = KSIZE * KSIZE;
    localparam int NPIX = conv_npix(IN_W, KSIZE);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(ROW - 1);
    localparam logic [CNT_W-1:0] WF_LAST = CNT_W'(ROW + FLUSH - 1);
    localparam logic [CNT_W-1:0] A_LAST  = CNT_W'(NPIX - 1);
    localparam logic [CNT_W-1:0] AF_LAST = CNT_W'(NPIX + FLUSH - 1);
    localparam logic [CNT_W-1:0] K_LAST  = CNT_W'(NKIJ - 1);

    conv_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, kij_q, kij_d;
    logic             l0_rd_q, l0_rd_d, l0_wr_q, l0_wr_d;
    logic [1:0]       inst_w_q, inst_w_d;
    logic             clr, kpos_step, act_step, sel_act;

    conv_addr_gen #(
        .ROW(ROW), .KSIZE(KSIZE), .IN_W(IN_W), .ADDR_W(ADDR_W), .ACT_BASE(ACT_BASE)
    ) u_addr (
        .clk(clk), .reset(reset), .clr(clr), .kpos_step(kpos_step), .act_step(act_step),
        .sel_act(sel_act), .wgt_cnt(cnt_q[ADDR_W-1:0]), .i_a(i_a)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        kij_d     = kij_q;
        i_cen     = 1'b1;
        of_rd     = 1'b0;
        p_cen     = 1'b1;
        p_wen     = 1'b1;
        p_a       = '0;
        clr       = 1'b0;
        kpos_step = 1'b0;
        act_step  = 1'b0;
        sel_act   = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                clr     = 1'b1;
                cnt_d   = '0;
                kij_d   = '0;
                state_d = S_WGT_LOAD;
            end
            S_WGT_LOAD: if (!l0_full) begin
                i_cen = 1'b0;
                if (cnt_q == W_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WGT_FEED;
                end else cnt_d = cnt_q + C_ONE;
            end
            S_WGT_FEED: if (cnt_q == WF_LAST) begin
                cnt_d   = '0;
                state_d = S_ACT_LOAD;
            end else cnt_d = cnt_q + C_ONE;
            S_ACT_LOAD: begin
                sel_act = 1'b1;
                if (!l0_full) begin
                    i_cen    = 1'b0;
                    act_step = 1'b1;
                    if (cnt_q == A_LAST) begin
                        cnt_d   = '0;
                        state_d = S_ACT_FEED;
                    end else cnt_d = cnt_q + C_ONE;
                end
            end
            S_ACT_FEED: if (cnt_q == AF_LAST) begin
                cnt_d   = '0;
                state_d = S_DRAIN;
            end else cnt_d = cnt_q + C_ONE;
            S_DRAIN: if (of_valid) begin
                of_rd = 1'b1;
                p_cen = 1'b0;
                p_wen = 1'b0;
                p_a   = cnt_q[ADDR_W-1:0];
                if (cnt_q == A_LAST) begin
                    cnt_d = '0;
                    if (kij_q == K_LAST) state_d = S_DONE;
                    else begin
                        kpos_step = 1'b1;
                        kij_d     = kij_q + C_ONE;
                        state_d   = S_WGT_LOAD;
                    end
                end else cnt_d = cnt_q + C_ONE;
            end
            S_DONE: begin
                clr     = 1'b1;
                kij_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Registered strobes are derived from the next state so they line up with it.
        l0_rd_d  = 1'b0;
        inst_w_d = INST_IDLE;
        if (state_d == S_WGT_FEED && cnt_d < CNT_W'(ROW)) begin
            l0_rd_d  = 1'b1;
            inst_w_d = INST_KLOAD;
        end
        if (state_d == S_ACT_FEED && cnt_d < CNT_W'(NPIX)) begin
            l0_rd_d  = 1'b1;
            inst_w_d = INST_EXEC;
        end
        l0_wr_d = ~i_cen;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            kij_q    <= '0;
            l0_rd_q  <= 1'b0;
            l0_wr_q  <= 1'b0;
            inst_w_q <= INST_IDLE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            kij_q    <= kij_d;
            l0_rd_q  <= l0_rd_d;
            l0_wr_q  <= l0_wr_d;
            inst_w_q <= inst_w_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign i_wen  = 1'b1;
    assign l0_rd  = l0_rd_q;
    assign l0_wr  = l0_wr_q;
    assign inst_w = inst_w_q;
    assign acc    = (kij_q != '0);

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - scoreboard bench for conv_sequencer (default and 1x1 kernel builds)
module tb_conv_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, l0_full, of_valid;
    logic       busy, done, i_cen, i_wen, l0_wr, l0_rd, of_rd, p_cen, p_wen, acc;
    logic [6:0] i_a, p_a;
    logic [1:0] inst_w;

    logic       start2, l0_full2, of_valid2;
    logic       busy2, done2, i_cen2, i_wen2, l0_wr2, l0_rd2, of_rd2, p_cen2, p_wen2, acc2;
    logic [6:0] i_a2, p_a2;
    logic [1:0] inst_w2;

    conv_sequencer dut (
        .clk(clk), .reset(rst), .start(start), .busy(busy), .done(done), .i_a(i_a),
        .i_cen(i_cen), .i_wen(i_wen), .l0_wr(l0_wr), .l0_rd(l0_rd), .l0_full(l0_full),
        .inst_w(inst_w), .of_valid(of_valid), .of_rd(of_rd), .p_a(p_a), .p_cen(p_cen),
        .p_wen(p_wen), .acc(acc)
    );

    conv_sequencer #(.KSIZE(1), .IN_W(4)) dut_k1 (
        .clk(clk), .reset(rst), .start(start2), .busy(busy2), .done(done2), .i_a(i_a2),
        .i_cen(i_cen2), .i_wen(i_wen2), .l0_wr(l0_wr2), .l0_rd(l0_rd2), .l0_full(l0_full2),
        .inst_w(inst_w2), .of_valid(of_valid2), .of_rd(of_rd2), .p_a(p_a2), .p_cen(p_cen2),
        .p_wen(p_wen2), .acc(acc2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    int exp_ia[$];
    int exp_pa[$];
    int exp_acc[$];
    int exp_ib[$];
    int exp_pb[$];
    logic mon_a = 1'b0;
    logic mon_b = 1'b0;
    int wr_cnt_a = 0;
    int e_pa, e_acc, e_pb;

    always @(negedge clk) begin
        if (!mon_a || rst) begin
            wr_cnt_a = 0;
        end else begin
            if (l0_wr === 1'b1) wr_cnt_a++;
            if (i_cen === 1'b0) begin
                if (exp_ia.size() == 0) chk("i_a_extra_read", exp_ia.size(), 1);
                else chk("i_a", i_a, exp_ia.pop_front());
            end
            if (of_rd === 1'b1) begin
                chk("pop_p_cen", p_cen, 0);
                chk("pop_p_wen", p_wen, 0);
                if (exp_pa.size() == 0) chk("pop_extra", exp_pa.size(), 1);
                else begin
                    e_pa  = exp_pa.pop_front();
                    e_acc = exp_acc.pop_front();
                    chk("p_a", p_a, e_pa);
                    chk("acc", acc, e_acc);
                    if (e_pa == 15) begin
                        chk("l0_wr_per_kij", wr_cnt_a, 24);
                        wr_cnt_a = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_b && !rst) begin
            if (i_cen2 === 1'b0) begin
                if (exp_ib.size() == 0) chk("k1_i_a_extra_read", exp_ib.size(), 1);
                else chk("k1_i_a", i_a2, exp_ib.pop_front());
            end
            if (of_rd2 === 1'b1) begin
                if (exp_pb.size() == 0) chk("k1_pop_extra", exp_pb.size(), 1);
                else begin
                    e_pb = exp_pb.pop_front();
                    chk("k1_p_a", p_a2, e_pb);
                    chk("k1_acc", acc2, 0);
                end
            end
        end
    end

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_i_a"}, i_a, 0);
        chk({tag, "_i_cen"}, i_cen, 1);
        chk({tag, "_i_wen"}, i_wen, 1);
        chk({tag, "_l0_wr"}, l0_wr, 0);
        chk({tag, "_l0_rd"}, l0_rd, 0);
        chk({tag, "_inst_w"}, inst_w, 0);
        chk({tag, "_of_rd"}, of_rd, 0);
        chk({tag, "_p_a"}, p_a, 0);
        chk({tag, "_p_cen"}, p_cen, 1);
        chk({tag, "_p_wen"}, p_wen, 1);
        chk({tag, "_acc"}, acc, 0);
    endtask

    task automatic build_a();
        exp_ia.delete();
        exp_pa.delete();
        exp_acc.delete();
        for (int kij = 0; kij < 9; kij++) begin
            for (int w = 0; w < 8; w++) exp_ia.push_back(kij * 8 + w);
            for (int oy = 0; oy < 4; oy++)
                for (int ox = 0; ox < 4; ox++)
                    exp_ia.push_back(72 + (kij / 3 + oy) * 6 + (kij % 3 + ox));
            for (int p = 0; p < 16; p++) begin
                exp_pa.push_back(p);
                exp_acc.push_back(kij != 0 ? 1 : 0);
            end
        end
    endtask

    task automatic run_a(input int stall_c, input int hold_c, input int exp_cyc, input int rst_kij);
        int cyc;
        int pops;
        int dones;
        bit fin;
        cyc = 0;
        pops = 0;
        dones = 0;
        fin = 1'b0;
        build_a();
        mon_a = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("first_i_a", i_a, 0);
        chk("first_i_cen", i_cen, 0);
        for (int t = 0; t < 5000 && !fin; t++) begin
            if (busy) cyc++;
            l0_full  = (stall_c > 0 && cyc >= stall_c && cyc < stall_c + 5);
            of_valid = !(hold_c > 0 && cyc >= hold_c && cyc < hold_c + 10);
            #1;
            if (stall_c > 0 && cyc == stall_c) chk("stall_i_cen", i_cen, 1);
            if (!of_valid) begin
                chk("hold_of_rd", of_rd, 0);
                chk("hold_p_cen", p_cen, 1);
            end
            if (of_rd) pops++;
            if (done) begin
                dones++;
                fin = 1'b1;
            end
            if (rst_kij >= 0 && pops == rst_kij * 16 && inst_w == 2'b10) begin
                rst = 1'b1;
                #1;
                chk_reset_outs("midrst");
                fin = 1'b1;
            end
            if (!fin) begin
                @(posedge clk); #1;
            end
        end
        l0_full  = 1'b0;
        of_valid = 1'b1;
        if (rst_kij >= 0) begin
            chk("midrst_reached", {31'd0, rst}, 1);
            mon_a = 1'b0;
            exp_ia.delete();
            exp_pa.delete();
            exp_acc.delete();
            @(posedge clk); #1 rst = 1'b0;
        end else begin
            chk("done_seen", dones, 1);
            chk("total_cycles", cyc, exp_cyc);
            repeat (2) @(posedge clk);
            #1;
            chk("after_done", done, 0);
            chk("after_busy", busy, 0);
            chk("ia_left", exp_ia.size(), 0);
            chk("pa_left", exp_pa.size(), 0);
            mon_a = 1'b0;
        end
    endtask

    task automatic run_b();
        int cyc;
        int dones;
        bit fin;
        cyc = 0;
        dones = 0;
        fin = 1'b0;
        exp_ib.delete();
        exp_pb.delete();
        for (int w = 0; w < 8; w++) exp_ib.push_back(w);
        for (int p = 0; p < 16; p++) begin
            exp_ib.push_back(72 + p);
            exp_pb.push_back(p);
        end
        mon_b = 1'b1;
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (int t = 0; t < 2000 && !fin; t++) begin
            if (busy2) cyc++;
            if (done2) begin
                dones++;
                fin = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("k1_done_seen", dones, 1);
        chk("k1_total_cycles", cyc, 97);
        repeat (2) @(posedge clk);
        #1;
        chk("k1_after_busy", busy2, 0);
        chk("k1_ia_left", exp_ib.size(), 0);
        chk("k1_pa_left", exp_pb.size(), 0);
        mon_b = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        start2    = 1'b0;
        l0_full   = 1'b0;
        of_valid  = 1'b1;
        l0_full2  = 1'b0;
        of_valid2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("rst");
        chk("rst_k1_busy", busy2, 0);
        chk("rst_k1_i_cen", i_cen2, 1);
        start = 1'b0;
        rst   = 1'b0;
        run_a(0, 0, 865, -1);
        run_a(37, 88, 880, -1);
        run_a(0, 0, 0, 3);
        run_a(0, 0, 865, -1);
        run_b();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
